dram_cmd_decoder: RTL and testbench

Receive-side counterpart of the DRAM signal generator. Samples the DDR4 command/address pins on every clock and decodes them into a command type plus rank/bank/row/column fields. Tracks per-bank open/closed state and open row, enforces tRCD/tRP/tRFC, and flags protocol violations. Sits in the DRAM behavioural model / checker on the device side of the signal-generator pin bundle.

---
 rtl/dram_pkg.sv | 31 +++
 rtl/dram_bank_tracker.sv | 61 ++++++
 rtl/dram_cmd_decoder.sv | 178 +++++++++++++++++
 tb/tb_dram_cmd_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types and geometry for the DDR4 command decoder and its per-bank tracker.
package dram_pkg;

  localparam int unsigned RANK_BITS       = 2;
  localparam int unsigned BANK_GROUP_BITS = 2;
  localparam int unsigned BANK_BITS       = 2;
  localparam int unsigned ADDR_BITS       = 14;
  localparam int unsigned ROW_BITS        = 16;
  localparam int unsigned COLUMN_BITS     = 10;
  localparam int unsigned BANK_IDX_BITS   = BANK_GROUP_BITS + BANK_BITS;
  localparam int unsigned NBANK           = 2 ** BANK_IDX_BITS;

  typedef enum logic [3:0] {
    DEC_DES,
    DEC_NOP,
    DEC_ACT,
    DEC_RD,
    DEC_WR,
    DEC_PRE,
    DEC_PREA,
    DEC_REF,
    DEC_MRS,
    DEC_ZQC
  } dec_cmd_t;

  // DES and NOP carry no work and are exempt from the tRFC check.
  function automatic logic is_real_cmd(dec_cmd_t c);
    return !(c == DEC_DES || c == DEC_NOP);
  endfunction

endpackage

// File: rtl/dram_bank_tracker.sv
// One bank-table entry: open flag, open row, and tRCD/tRP down-counters.
module dram_bank_tracker
  import dram_pkg::*;
#(
  parameter int unsigned T_RCD = 16,
  parameter int unsigned T_RP  = 16,
  parameter int unsigned TW    = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                act_i,
  input  logic                pre_i,
  input  logic                prea_i,
  input  logic [ROW_BITS-1:0] row_i,
  output logic                is_open_o,
  output logic [ROW_BITS-1:0] row_o,
  output logic                rcd_busy_o,
  output logic                rp_busy_o
);

  logic                open_q, open_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [TW-1:0]       rcd_q, rcd_d;
  logic [TW-1:0]       rp_q, rp_d;

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    rcd_d  = (rcd_q != '0) ? rcd_q - TW'(1) : '0;
    rp_d   = (rp_q != '0) ? rp_q - TW'(1) : '0;
    // ACT to an open bank and PRE to a closed bank leave the entry untouched.
    if (act_i && !open_q) begin
      open_d = 1'b1;
      row_d  = row_i;
      rcd_d  = TW'(T_RCD - 1);
    end else if ((pre_i || prea_i) && open_q) begin
      open_d = 1'b0;
      rp_d   = TW'(T_RP - 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      open_q <= 1'b0;
      row_q  <= '0;
      rcd_q  <= '0;
      rp_q   <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
      rcd_q  <= rcd_d;
      rp_q   <= rp_d;
    end
  end

  assign is_open_o  = open_q;
  assign row_o      = row_q;
  assign rcd_busy_o = (rcd_q != '0);
  assign rp_busy_o  = (rp_q != '0);

endmodule

// File: rtl/dram_cmd_decoder.sv
// Device-side DDR4 command decoder: registered command/fields, bank table and
// tRCD/tRP/tRFC protocol checks.
module dram_cmd_decoder
  import dram_pkg::*;
#(
  parameter int unsigned T_RCD = 16,
  parameter int unsigned T_RP  = 16,
  parameter int unsigned T_RFC = 350,
  parameter int unsigned TW    = 10
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CKE,
  input  logic                       CS_n,
  input  logic                       ACT_n,
  input  logic                       RAS_n_A16,
  input  logic                       CAS_n_A15,
  input  logic                       WE_n_A14,
  input  logic                       ADDR_17,
  input  logic [RANK_BITS-1:0]       C,
  input  logic [BANK_GROUP_BITS-1:0] BG,
  input  logic [BANK_BITS-1:0]       BA,
  input  logic [ADDR_BITS-1:0]       ADDR,
  output dec_cmd_t                   cmd,
  output logic                       cmd_valid,
  output logic [RANK_BITS-1:0]       rank,
  output logic [BANK_IDX_BITS-1:0]   bank,
  output logic [ROW_BITS-1:0]        row,
  output logic [COLUMN_BITS-1:0]     col,
  output logic                       err_act_open,
  output logic                       err_closed,
  output logic                       err_trcd,
  output logic                       err_trp,
  output logic                       err_trfc,
  output logic                       err_ref_open,
  output logic                       err_any
);

  dec_cmd_t                 dec_cmd;
  logic [BANK_IDX_BITS-1:0] bank_idx;
  logic [ROW_BITS-1:0]      act_row;
  logic                     is_act, is_rdwr, is_ref;

  logic [NBANK-1:0]    bank_open, rcd_busy, rp_busy, act_vec, pre_vec;
  logic [ROW_BITS-1:0] bank_row [NBANK];

  logic [TW-1:0] trfc_q, trfc_d;

  dec_cmd_t                 cmd_q;
  logic                     valid_q, valid_d;
  logic [RANK_BITS-1:0]     rank_q, rank_d;
  logic [BANK_IDX_BITS-1:0] bank_q, bank_d;
  logic [ROW_BITS-1:0]      row_q, row_d;
  logic [COLUMN_BITS-1:0]   col_q, col_d;
  logic [5:0]               err_q, err_d;
  logic                     err_any_q;

  assign bank_idx = {BG, BA};
  assign act_row  = ROW_BITS'({ADDR_17, RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR});

  always_comb begin
    dec_cmd = DEC_DES;
    if (CKE && !CS_n) begin
      if (!ACT_n) begin
        dec_cmd = DEC_ACT;
      end else begin
        unique case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
          3'b000:  dec_cmd = DEC_MRS;
          3'b001:  dec_cmd = DEC_REF;
          3'b010:  dec_cmd = ADDR[10] ? DEC_PREA : DEC_PRE;
          3'b011:  dec_cmd = DEC_NOP;
          3'b100:  dec_cmd = DEC_WR;
          3'b101:  dec_cmd = DEC_RD;
          3'b110:  dec_cmd = DEC_ZQC;
          default: dec_cmd = DEC_NOP;
        endcase
      end
    end
  end

  assign is_act  = (dec_cmd == DEC_ACT);
  assign is_rdwr = (dec_cmd == DEC_RD) || (dec_cmd == DEC_WR);
  assign is_ref  = (dec_cmd == DEC_REF);

  for (genvar i = 0; i < int'(NBANK); i++) begin : g_bank
    assign act_vec[i] = is_act && (bank_idx == BANK_IDX_BITS'(i));
    assign pre_vec[i] = (dec_cmd == DEC_PRE) && (bank_idx == BANK_IDX_BITS'(i));

    dram_bank_tracker #(
      .T_RCD(T_RCD),
      .T_RP (T_RP),
      .TW   (TW)
    ) u_bank (
      .clk_i     (CLK),
      .rst_i     (RST),
      .act_i     (act_vec[i]),
      .pre_i     (pre_vec[i]),
      .prea_i    (dec_cmd == DEC_PREA),
      .row_i     (act_row),
      .is_open_o (bank_open[i]),
      .row_o     (bank_row[i]),
      .rcd_busy_o(rcd_busy[i]),
      .rp_busy_o (rp_busy[i])
    );
  end

  // All checks look at the table as it stood before this edge's update.
  always_comb begin
    valid_d = is_real_cmd(dec_cmd);
    rank_d  = '0;
    bank_d  = '0;
    row_d   = '0;
    col_d   = '0;
    if (dec_cmd != DEC_DES) begin
      rank_d = C;
      bank_d = bank_idx;
    end
    // RD/WR report the row currently open in the addressed bank.
    if (is_act) begin
      row_d = act_row;
    end else if (is_rdwr) begin
      col_d = ADDR[COLUMN_BITS-1:0];
      if (bank_open[bank_idx]) row_d = bank_row[bank_idx];
    end

    err_d[5] = is_act && bank_open[bank_idx];
    err_d[4] = is_rdwr && !bank_open[bank_idx];
    err_d[3] = is_rdwr && bank_open[bank_idx] && rcd_busy[bank_idx];
    err_d[2] = is_act && rp_busy[bank_idx];
    err_d[1] = valid_d && (trfc_q != '0);
    err_d[0] = is_ref && (|bank_open);

    if (is_ref) begin
      trfc_d = TW'(T_RFC - 1);
    end else begin
      trfc_d = (trfc_q != '0) ? trfc_q - TW'(1) : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cmd_q     <= DEC_DES;
      valid_q   <= 1'b0;
      rank_q    <= '0;
      bank_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      err_q     <= '0;
      err_any_q <= 1'b0;
      trfc_q    <= '0;
    end else begin
      cmd_q     <= dec_cmd;
      valid_q   <= valid_d;
      rank_q    <= rank_d;
      bank_q    <= bank_d;
      row_q     <= row_d;
      col_q     <= col_d;
      err_q     <= err_d;
      err_any_q <= err_any_q | (|err_d);
      trfc_q    <= trfc_d;
    end
  end

  assign cmd          = cmd_q;
  assign cmd_valid    = valid_q;
  assign rank         = rank_q;
  assign bank         = bank_q;
  assign row          = row_q;
  assign col          = col_q;
  assign err_act_open = err_q[5];
  assign err_closed   = err_q[4];
  assign err_trcd     = err_q[3];
  assign err_trp      = err_q[2];
  assign err_trfc     = err_q[1];
  assign err_ref_open = err_q[0];
  assign err_any      = err_any_q;

endmodule

// File: tb/tb_dram_cmd_decoder.sv
// Scoreboard bench: a cycle-stamp reference model predicts each registered output.
module tb_dram_cmd_decoder;
  import dram_pkg::*;

  localparam int T_RCD = 16;
  localparam int T_RP  = 16;
  localparam int T_RFC = 350;
  localparam int NEVER = -100000;

  logic                       CLK = 1'b0;
  logic                       RST, CKE, CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR_17;
  logic [RANK_BITS-1:0]       C;
  logic [BANK_GROUP_BITS-1:0] BG;
  logic [BANK_BITS-1:0]       BA;
  logic [ADDR_BITS-1:0]       ADDR;
  dec_cmd_t                   cmd;
  logic                       cmd_valid;
  logic [RANK_BITS-1:0]       rank;
  logic [BANK_IDX_BITS-1:0]   bank;
  logic [ROW_BITS-1:0]        row;
  logic [COLUMN_BITS-1:0]     col;
  logic err_act_open, err_closed, err_trcd, err_trp, err_trfc, err_ref_open, err_any;

  dram_cmd_decoder #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .TW(10)) dut (
    .CLK(CLK), .RST(RST), .CKE(CKE), .CS_n(CS_n), .ACT_n(ACT_n),
    .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14), .ADDR_17(ADDR_17),
    .C(C), .BG(BG), .BA(BA), .ADDR(ADDR),
    .cmd(cmd), .cmd_valid(cmd_valid), .rank(rank), .bank(bank), .row(row), .col(col),
    .err_act_open(err_act_open), .err_closed(err_closed), .err_trcd(err_trcd),
    .err_trp(err_trp), .err_trfc(err_trfc), .err_ref_open(err_ref_open), .err_any(err_any)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    dec_cmd_t                 cmd;
    logic                     valid;
    logic [RANK_BITS-1:0]     rank;
    logic [BANK_IDX_BITS-1:0] bank;
    logic [ROW_BITS-1:0]      row;
    logic [COLUMN_BITS-1:0]   col;
    logic [6:0]               err;  // act_open, closed, trcd, trp, trfc, ref_open, any
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;

  bit m_open  [NBANK];
  int m_row   [NBANK];
  int act_cyc [NBANK];
  int pre_cyc [NBANK];
  int ref_cyc;
  bit m_any;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NBANK); i++) begin
      m_open[i] = 0; m_row[i] = 0; act_cyc[i] = NEVER; pre_cyc[i] = NEVER;
    end
    ref_cyc = NEVER;
    m_any   = 0;
  endtask

  // Drive one command for one clock, predict the outputs, then compare them.
  task automatic step(input dec_cmd_t k, input int b, input int a, input bit cke, input bit rst);
    exp_t                 e, g;
    dec_cmd_t             ek;
    logic [RANK_BITS-1:0] rk;
    logic [5:0]           er;
    bit                   any_open;
    rk = RANK_BITS'($urandom);
    RST = rst; CKE = cke; C = rk; {BG, BA} = BANK_IDX_BITS'(b);
    CS_n = (k == DEC_DES); ACT_n = 1'b1; ADDR_17 = 1'($urandom);
    ADDR = ADDR_BITS'($urandom);
    {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'($urandom);
    case (k)
      DEC_ACT: begin
        ACT_n = 1'b0;
        {ADDR_17, RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR} = 18'(a);
      end
      DEC_MRS: {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b000;
      DEC_REF: {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b001;
      DEC_PRE: begin {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b010; ADDR[10] = 1'b0; end
      DEC_PREA: begin {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b010; ADDR[10] = 1'b1; end
      DEC_NOP: {RAS_n_A16, CAS_n_A15, WE_n_A14} = $urandom_range(0, 1) ? 3'b111 : 3'b011;
      DEC_RD: begin {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b101; ADDR[9:0] = 10'(a); end
      DEC_WR: begin {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b100; ADDR[9:0] = 10'(a); end
      DEC_ZQC: {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b110;
      default: ;
    endcase

    e = '0;
    if (rst) begin
      model_reset();
    end else begin
      ek = cke ? k : DEC_DES;
      e.cmd   = ek;
      e.valid = (ek != DEC_DES) && (ek != DEC_NOP);
      if (ek != DEC_DES) begin
        e.rank = rk;
        e.bank = BANK_IDX_BITS'(b);
      end
      any_open = 0;
      for (int i = 0; i < int'(NBANK); i++) any_open |= m_open[i];
      er = '0;
      er[1] = e.valid && (cyc - ref_cyc < T_RFC);
      case (ek)
        DEC_ACT: begin
          e.row = ROW_BITS'(a);
          er[5] = m_open[b];
          er[2] = (cyc - pre_cyc[b] < T_RP);
          if (!m_open[b]) begin
            m_open[b] = 1; m_row[b] = a & 'hFFFF; act_cyc[b] = cyc;
          end
        end
        DEC_RD, DEC_WR: begin
          e.col = COLUMN_BITS'(a);
          if (!m_open[b]) er[4] = 1;
          else begin
            e.row = ROW_BITS'(m_row[b]);
            er[3] = (cyc - act_cyc[b] < T_RCD);
          end
        end
        DEC_PRE: if (m_open[b]) begin m_open[b] = 0; pre_cyc[b] = cyc; end
        DEC_PREA: for (int i = 0; i < int'(NBANK); i++)
          if (m_open[i]) begin m_open[i] = 0; pre_cyc[i] = cyc; end
        DEC_REF: begin er[0] = any_open; ref_cyc = cyc; end
        default: ;
      endcase
      m_any = m_any | (|er);
      e.err = {er, m_any};
    end
    sb_q.push_back(e);

    @(posedge CLK);
    cyc++;
    #1;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      g = '{cmd: cmd, valid: cmd_valid, rank: rank, bank: bank, row: row, col: col,
            err: {err_act_open, err_closed, err_trcd, err_trp, err_trfc, err_ref_open, err_any}};
      check_eq("cmd", 64'(g.cmd), 64'(e.cmd));
      check_eq("cmd_valid", 64'(g.valid), 64'(e.valid));
      check_eq("fields", 64'({g.rank, g.bank, g.row, g.col}), 64'({e.rank, e.bank, e.row, e.col}));
      check_eq("errors", 64'(g.err), 64'(e.err));
    end
  endtask

  task automatic idle(input int count);
    for (int i = 0; i < count; i++)
      step((i % 2) ? DEC_NOP : DEC_DES, $urandom_range(0, NBANK - 1), 0, 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    step(DEC_DES, 0, 0, 1, 1);
    step(DEC_DES, 0, 0, 1, 1);

    // Clean ACT -> RD exactly tRCD apart
    step(DEC_ACT, 3, 'h1A5, 1, 0);
    idle(15);
    step(DEC_RD, 3, 'h40, 1, 0);

    // RD one cycle early violates tRCD; err_any stays set afterwards
    step(DEC_PRE, 3, 0, 1, 0);
    idle(15);
    step(DEC_ACT, 3, 'h22, 1, 0);
    idle(14);
    step(DEC_RD, 3, 'h41, 1, 0);
    idle(2);
    step(DEC_WR, 3, 'h3FF, 1, 0);

    // Double ACT and access to a never-opened bank
    step(DEC_ACT, 5, 'h100, 1, 0);
    step(DEC_ACT, 5, 'h200, 1, 0);
    step(DEC_RD, 6, 'h12, 1, 0);

    // PREA, then tRP boundary on two banks
    step(DEC_ACT, 0, 'h10, 1, 0);
    step(DEC_ACT, 7, 'h70, 1, 0);
    step(DEC_ACT, 15, 'h3FFFF, 1, 0);
    step(DEC_PREA, 0, 0, 1, 0);
    idle(14);
    step(DEC_ACT, 7, 'h71, 1, 0);
    step(DEC_ACT, 0, 'h11, 1, 0);

    // REF with a bank open, then the tRFC boundary
    step(DEC_PREA, 0, 0, 1, 0);
    idle(16);
    step(DEC_ACT, 2, 'h2A, 1, 0);
    step(DEC_REF, 0, 0, 1, 0);
    idle(350);
    step(DEC_PREA, 0, 0, 1, 0);
    step(DEC_REF, 0, 0, 1, 0);
    idle(348);
    step(DEC_ACT, 1, 'h1, 1, 0);
    step(DEC_ACT, 4, 'h4, 1, 0);
    step(DEC_MRS, 0, 0, 1, 0);
    step(DEC_ZQC, 0, 0, 1, 0);
    step(DEC_NOP, 0, 0, 1, 0);

    // CKE low masks a valid ACT; RST discards a command and clears the table
    step(DEC_ACT, 10, 'h1234, 0, 0);
    step(DEC_ACT, 9, 'h999, 1, 0);
    step(DEC_ACT, 0, 'h55, 1, 1);
    step(DEC_RD, 0, 'h10, 1, 0);
    step(DEC_RD, 9, 'h20, 1, 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
